// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_TAKEN = 2'b01;
    localparam logic [1:0] BR_JAL   = 2'b10;
    localparam logic [1:0] BR_JALR  = 2'b11;

    localparam int unsigned STG_ID  = 0;
    localparam int unsigned STG_EX  = 1;
    localparam int unsigned STG_MEM = 2;
    localparam int unsigned STG_WB  = 3;
    localparam int unsigned NUM_STG = 4;

endpackage

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait-state FSM with timeout watchdog; freezes the pipeline while an
// access is outstanding and pulses mem_err_o when the watchdog expires.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mem_req_i,
    input  logic mem_ready_i,
    output logic freeze_o,
    output logic mem_err_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = 1'b0;
        freeze_o  = 1'b0;
        unique case (state_q)
            RUN: begin
                // A same-cycle ready completes with no penalty.
                if (mem_req_i && !mem_ready_i) begin
                    freeze_o = 1'b1;
                    state_d  = MEM_WAIT;
                    cnt_d    = '0;
                end
            end
            MEM_WAIT: begin
                freeze_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == LastCnt) begin
                    mem_err_d = 1'b1;
                    state_d   = RUN;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err_o = mem_err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use/redirect handling, memory-wait freeze
// and per-instruction retire tracking for the 5-stage core.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned TIMEOUT    = 256,
    parameter int unsigned CNT_W      = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mem_read,
    input  logic [1:0]            ex_branch,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  back_we,
    output logic                  lw_use,
    output logic [1:0]            branch,
    output logic                  retire,
    output logic                  mem_err
);

    logic               freeze;
    logic               hz;
    logic               br;
    logic [NUM_STG-1:0] valid_q, valid_d;

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_mem_wait_fsm (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_req_i   (mem_req),
        .mem_ready_i (mem_ready),
        .freeze_o    (freeze),
        .mem_err_o   (mem_err)
    );

    assign hz = ex_mem_read && (ex_rd_addr != '0) &&
                ((id_use_rs1 && (ex_rd_addr == id_rs1_addr)) ||
                 (id_use_rs2 && (ex_rd_addr == id_rs2_addr)));
    assign br = (ex_branch != BR_NONE);

    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        back_we     = 1'b0;
        lw_use      = 1'b0;
        branch      = BR_NONE;
        if (rst) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (!freeze) begin
            back_we = 1'b1;
            // Redirect squashes the ID instruction, so it outranks load-use.
            if (br) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                pc_we       = 1'b1;
                branch      = ex_branch;
            end else if (hz) begin
                id_ex_flush = 1'b1;
                lw_use      = 1'b1;
            end else begin
                pc_we    = 1'b1;
                if_id_we = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (back_we) begin
            valid_d[STG_WB]  = valid_q[STG_MEM];
            valid_d[STG_MEM] = valid_q[STG_EX];
            valid_d[STG_EX]  = id_ex_flush ? 1'b0 : valid_q[STG_ID];
            if (if_id_flush) begin
                valid_d[STG_ID] = 1'b0;
            end else if (if_id_we) begin
                valid_d[STG_ID] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign retire = valid_q[STG_WB] && back_we;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage core.
- Sits between the ID/EX decode logic and the pipeline registers. Drives per-stage write-enable and flush controls.
- Produces the lw_use and branch indications consumed by the CSR counter block, plus an explicit per-instruction retire pulse.
- Adds a data-memory wait-state FSM with a timeout watchdog, so the pipeline freezes cleanly on slow memory.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- TIMEOUT, 256, maximum MEM_WAIT cycles before the watchdog fires (at least 2).
- CNT_W, 9, width of the wait counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- id_rs1_addr  in  REG_ADDR_W  rs1 of instruction in ID
- id_rs2_addr  in  REG_ADDR_W  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd_addr  in  REG_ADDR_W  rd of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch  in  2  00 none, 01 taken branch, 10 jal, 11 jalr (already resolved taken/not)
- mem_req  in  1  MEM stage issues a dmem access this cycle
- mem_ready  in  1  dmem completes the access this cycle
- pc_we  out  1  PC write enable
- if_id_we  out  1  IF/ID register write enable
- if_id_flush  out  1  IF/ID register clear
- id_ex_flush  out  1  ID/EX register insert bubble
- back_we  out  1  write enable shared by ID/EX, EX/MEM and MEM/WB
- lw_use  out  1  load-use stall indication (to CSR)
- branch  out  2  redirect indication (to CSR), encoding as ex_branch
- retire  out  1  one instruction leaves WB this cycle
- mem_err  out  1  one-cycle dmem timeout pulse

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- State on reset: state=RUN, wait_cnt=0, valid[ID,EX,MEM,WB]=0, mem_err=0.
- Outputs while rst is high: pc_we=0, if_id_we=0, back_we=0, if_id_flush=1, id_ex_flush=1, lw_use=0, branch=00, retire=0.
- Load-use detect (combinational): hz = ex_mem_read & (ex_rd_addr!=0) & ((id_use_rs1 & ex_rd_addr==id_rs1_addr) | (id_use_rs2 & ex_rd_addr==id_rs2_addr)).
- Redirect detect: br = (ex_branch!=00).
- FSM has two states, RUN and MEM_WAIT.
- RUN, normal case: back_we=1.
  - If br: if_id_flush=1, id_ex_flush=1, pc_we=1, branch=ex_branch, lw_use=0. Branch wins over load-use because the ID instruction is squashed.
  - Else if hz: pc_we=0, if_id_we=0, id_ex_flush=1, lw_use=1.
  - Else: pc_we=1, if_id_we=1, no flush.
- RUN -> MEM_WAIT when mem_req & !mem_ready. In that same cycle, freeze:
  - pc_we, if_id_we and back_we are 0.
  - All flushes are 0, lw_use=0, branch=00.
  - br/hz are ignored and re-evaluated after the freeze.
- MEM_WAIT: stays frozen, wait_cnt increments each cycle.
  - On mem_ready: go to RUN, wait_cnt=0. The freeze holds through the mem_ready cycle, and the pipeline advances the following cycle.
  - On wait_cnt==TIMEOUT-1 with !mem_ready: mem_err=1 for exactly one cycle, go to RUN, wait_cnt=0.
  - mem_ready on the same cycle as timeout counts as completion; no mem_err.
- mem_req & mem_ready together in RUN: no stall, zero penalty.
- Retire tracking: valid bits shift ID->EX->MEM->WB when back_we=1 and are held when frozen.
  - valid[ID] loads 1 when if_id_we=1, and loads 0 when if_id_flush=1.
  - id_ex_flush inserts valid[EX]=0.
  - retire = valid[WB] & back_we. Freeze cycles never retire.
- lw_use and branch are forced low during any freeze, so CSR counting sees no spurious events.
- Mid-operation reset: a reset in MEM_WAIT returns to RUN next cycle, with no mem_err.

Decomposition:
- Shared package, hazard_pkg:
  - state enum {RUN, MEM_WAIT};
  - branch encoding constants BR_NONE/BR_TAKEN/BR_JAL/BR_JALR;
  - stage-index constants for the valid vector.
- One sub-module, mem_wait_fsm, holds the state, wait_cnt and mem_err logic. It exports a freeze signal; the hazard/flush combinational logic and the valid shifter stay in the top.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs1_addr=5, id_use_rs1=1 -> lw_use=1, pc_we=0, if_id_we=0, id_ex_flush=1 for 1 cycle. Same with ex_rd_addr=0 -> lw_use=0.
- Branch plus hazard in the same cycle: ex_branch=01 with a load-use match -> branch=01, lw_use=0, if_id_flush=1, id_ex_flush=1, pc_we=1.
- Memory wait: mem_req=1, mem_ready low 3 cycles then high -> 4 frozen cycles (pc_we=back_we=0), RUN on cycle 5. Retire count is unchanged during the freeze.
- Timeout: TIMEOUT=8, mem_ready never asserted -> mem_err=1 exactly once, 8 cycles after entry, then RUN. Completion on cycle 8 -> mem_err=0.
- Retire accounting: 10 back-to-back ALU instructions after reset -> first retire 4 cycles after the first if_id_we, then 10 retires in total. With one taken branch inserted -> 2 fewer retires.
- Reset mid-MEM_WAIT: rst pulsed while in MEM_WAIT -> next cycle state=RUN, all valid=0, retire=0, mem_err=0.
